// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data, occupancy count,
// registered full/empty flags and sticky overflow/underflow error flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fifo_words,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  // Handshake: a write is taken on any rising edge with wr_en high while the
  // FIFO is not full, or while it is full but a read is taken on that same
  // edge. A read is taken on any rising edge with rd_en high while not empty.
  // A request that is not taken is dropped and latches its sticky error flag.
  // A taken read returns its word on rd_data, with rd_valid high, for exactly
  // the one cycle that follows the edge.

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic rd_acc;
  logic wr_acc;

  always_comb begin
    rd_acc = rd_en && !empty_q;
    // A full FIFO can still take a write when a read frees a slot on the same edge.
    wr_acc = wr_en && (!full_q || rd_acc);
  end

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (rd_acc) begin
      rd_data_d  = mem[rp_q];
      rd_valid_d = 1'b1;
      rp_d       = rp_q + 1'b1;
    end

    if (wr_acc) begin
      wp_d = wp_q + 1'b1;
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end

    if (wr_en && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (rd_en && !rd_acc) begin
      underflow_d = 1'b1;
    end

    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset. When full with a simultaneous read, wp == rp, and the
  // read above samples the old word before this write replaces it.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp_q] <= wr_data;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign fifo_words = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a cycle-level occupancy model and an expected
// data queue predict every output, one step per clock.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [3:0] fifo_words;
  logic       overflow;
  logic       underflow;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .full       (full),
    .empty      (empty),
    .fifo_words (fifo_words),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference model state
  logic [7:0] exp_q[$];
  int         m_cnt;
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] m_last;
  int         checks;
  int         failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_last = 8'h00;
  endtask

  // One clock: drive at the falling edge, predict, check at the next falling edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    logic ra;
    logic wa;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    ra = rd && (m_cnt != 0);
    wa = wr && ((m_cnt != 8) || ra);
    @(posedge clk);
    if (ra) m_last = exp_q.pop_front();
    if (wa) exp_q.push_back(d);
    if (wa && !ra) m_cnt++;
    else if (ra && !wa) m_cnt--;
    if (wr && !wa) m_ovf = 1'b1;
    if (rd && !ra) m_unf = 1'b1;
    @(negedge clk);
    check("rd_valid", rd_valid, ra);
    check("rd_data", rd_data, m_last);
    check("fifo_words", fifo_words, m_cnt);
    check("full", full, m_cnt == 8);
    check("empty", empty, m_cnt == 0);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
  endtask

  task automatic drain();
    while (m_cnt > 0) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data"}, rd_data, 8'h00);
    check({tag, "_rd_valid"}, rd_valid, 1'b0);
    check({tag, "_full"}, full, 1'b0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_fifo_words"}, fifo_words, 4'd0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_underflow"}, underflow, 1'b0);
  endtask

  initial begin
    logic writing;
    logic [7:0] pat;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    rd_en    = 1'b0;
    model_reset();

    // reset and idle
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    rst = 1'b0;
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check_reset_outputs("after_reset");

    // fill, overflow attempt, ordered read-out
    for (int i = 0; i < 8; i++) step(1'b1, 8'h11 + 8'(i), 1'b0);
    check("filled_full", full, 1'b1);
    step(1'b1, 8'h99, 1'b0);
    check("overflow_set", overflow, 1'b1);
    check("overflow_count", fifo_words, 4'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("readout_order", rd_data, 8'h11 + 8'(i));
    end
    step(1'b0, 8'h00, 1'b0);
    check("readout_empty", empty, 1'b1);

    // upstream hysteresis writer against a slow reader
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    writing = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step(writing && (m_cnt < 5), 8'hAA, (c % 4) == 3);
      check("hyst_range", fifo_words <= 4'd6, 1'b1);
      if (rd_valid) check("hyst_data", rd_data, 8'hAA);
      if (m_cnt >= 5) writing = 1'b0;
      else if (m_cnt <= 2) writing = 1'b1;
    end
    check("hyst_no_overflow", overflow, 1'b0);
    drain();

    // full with simultaneous read and write, across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    pat = 8'($urandom_range(0, 200));
    for (int i = 0; i < 10; i++) begin
      step(1'b1, pat + 8'(i), 1'b1);
      check("full_rw_count", fifo_words, 4'd8);
      check("full_rw_full", full, 1'b1);
    end
    check("full_rw_no_overflow", overflow, 1'b0);
    drain();

    // empty with simultaneous read and write: no fall-through
    step(1'b1, 8'h5C, 1'b1);
    check("empty_rw_underflow", underflow, 1'b1);
    check("empty_rw_count", fifo_words, 4'd1);
    check("empty_rw_valid", rd_valid, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("empty_rw_data", rd_data, 8'h5C);
    check("empty_rw_valid2", rd_valid, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // asynchronous reset in the middle of a read
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    step(1'b1, 8'h99, 1'b1);
    check("pre_rst_valid", rd_valid, 1'b1);
    wr_en = 1'b0;
    rd_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rd_en = 1'b0;
    model_reset();
    check_reset_outputs("rst_held");
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    check_reset_outputs("rst_released");
    step(1'b1, 8'h42, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_data", rd_data, 8'h42);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
